// File: rtl/onehot5_stage_reg.sv
// One-entry 1-of-5 decode stage with error accounting and lockout after
// LOCK_N consecutive bad words; clr_err releases the lock and clears status.
module onehot5_stage_reg #(
  parameter int CNT_W  = 8,
  parameter int LOCK_N = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [4:0]       in_data,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       out_idx,
  output logic             out_err,
  output logic [CNT_W-1:0] err_cnt,
  output logic             err_sticky,
  output logic             locked,
  input  logic             clr_err
);

  typedef enum logic {RUN = 1'b0, LOCK = 1'b1} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [2:0]       LOCK_TH = 3'(LOCK_N);

  state_t           r_state, w_state_nxt;
  logic             r_out_valid;
  logic [2:0]       r_out_idx;
  logic             r_out_err;
  logic [CNT_W-1:0] r_err_cnt;
  logic             r_err_sticky;
  logic [2:0]       r_consec, w_consec_nxt;

  logic             w_in_ready;
  logic             w_accept;
  logic             w_err_acc;
  logic [2:0]       w_dec_idx;
  logic             w_dec_err;

  always_comb begin
    w_dec_idx = 3'd7;
    w_dec_err = 1'b1;
    unique case (in_data)
      5'b00001: begin w_dec_idx = 3'd0; w_dec_err = 1'b0; end
      5'b00010: begin w_dec_idx = 3'd1; w_dec_err = 1'b0; end
      5'b00100: begin w_dec_idx = 3'd2; w_dec_err = 1'b0; end
      5'b01000: begin w_dec_idx = 3'd3; w_dec_err = 1'b0; end
      5'b10000: begin w_dec_idx = 3'd4; w_dec_err = 1'b0; end
      default:  begin w_dec_idx = 3'd7; w_dec_err = 1'b1; end
    endcase
  end

  assign w_accept  = in_valid & w_in_ready;
  assign w_err_acc = w_accept & w_dec_err;

  // An error accepted alongside clr_err wins: the run restarts at one.
  always_comb begin
    w_consec_nxt = r_consec;
    if (w_err_acc)
      w_consec_nxt = clr_err ? 3'd1 : ((r_consec == 3'd7) ? 3'd7 : r_consec + 3'd1);
    else if (clr_err || w_accept)
      w_consec_nxt = 3'd0;
  end

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= RUN;
    else     r_state <= w_state_nxt;
  end

  // FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      RUN:  if (w_err_acc && w_consec_nxt == LOCK_TH) w_state_nxt = LOCK;
      LOCK: if (clr_err) w_state_nxt = RUN;
      default: w_state_nxt = RUN;
    endcase
  end

  // FSM: outputs
  always_comb begin
    locked     = (r_state == LOCK);
    w_in_ready = (r_state == RUN) && (!r_out_valid || out_ready);
  end

  // Output register: reload on accept, empty on drain, hold otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_idx   <= 3'd0;
      r_out_err   <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_idx   <= w_dec_idx;
      r_out_err   <= w_dec_err;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_cnt    <= '0;
      r_err_sticky <= 1'b0;
      r_consec     <= 3'd0;
    end else begin
      r_consec <= w_consec_nxt;
      if (w_err_acc) begin
        r_err_sticky <= 1'b1;
        if (clr_err)                r_err_cnt <= CNT_W'(1);
        else if (r_err_cnt != CNT_MAX) r_err_cnt <= r_err_cnt + CNT_W'(1);
      end else if (clr_err) begin
        r_err_cnt    <= '0;
        r_err_sticky <= 1'b0;
      end
    end
  end

  assign in_ready   = w_in_ready;
  assign out_valid  = r_out_valid;
  assign out_idx    = r_out_idx;
  assign out_err    = r_out_err;
  assign err_cnt    = r_err_cnt;
  assign err_sticky = r_err_sticky;

endmodule
